button_reader: RTL and testbench
================================

# button_reader

Debounced single-button input reader: the input-side counterpart to the board's LED pattern drivers. It synchronizes one raw pushbutton pin into the `Clock` domain and filters contact bounce. It reports a clean held level plus one-cycle press, release, long-press and (optionally) auto-repeat events. It also keeps a running press count, so pattern logic can change mode or speed from user input. One instance is used per board button.

## Interface
- `CLOCK_FREQUENCY`, 27000000, `Clock` frequency in Hz.
- `DEBOUNCE_MS`, 10, required stable time in ms; must be ≥1. D = (CLOCK_FREQUENCY/1000)*DEBOUNCE_MS.
- `LONG_PRESS_MS`, 1000, hold time for a long press. L = (CLOCK_FREQUENCY/1000)*LONG_PRESS_MS; must satisfy L > 1.
- `REPEAT_MS`, 200, auto-repeat period. R = (CLOCK_FREQUENCY/1000)*REPEAT_MS; must be ≥1.
- `ACTIVE_LOW`, 1, 1 = pin reads 0 when pressed; 0 = pin reads 1 when pressed.

- `Clock` input 1: sole clock, rising edge.
- `Reset_n` input 1: asynchronous, active-low reset.
- `Button_raw` input 1: asynchronous pin from the board button.
- `Pressed` output 1: debounced level, 1 = held.
- `Press_pulse` output 1: one-cycle strobe on accepted press.
- `Release_pulse` output 1: one-cycle strobe on accepted release.
- `Long_pulse` output 1: one-cycle strobe when a hold reaches L cycles.
- `Repeat_pulse` output 1: one-cycle auto-repeat strobe; tied 0 when `BUTTON_REPEAT_EN` is undefined.
- `Press_count` output 8: accepted presses, modulo 256.

## Operation
- **Synchronizer**
  - Two-flop synchronizer on `Button_raw`, normalized by `ACTIVE_LOW` so that 1 = pressed.
  - Reset value of both flops is the released level.
- **Debounce counter**
  - Width is $clog2(D+1).
  - Increments on each cycle that the synchronized value differs from `Pressed`.
  - Clears to 0 on any cycle where they match, so a bounce restarts the count.
  - When the count reaches D, the new level is accepted and the counter clears.
- **FSM states**
  - IDLE: released.
  - HELD: pressed, long timer running.
  - LONG: long press reached, repeat timer running.
- **Transitions**
  - IDLE → HELD on accepted press: `Pressed`←1, `Press_pulse`, `Press_count`+1 (wraps 255→0), hold counter←0.
  - HELD: the hold counter increments every cycle. When it reaches L−1, go to LONG and assert `Long_pulse`; the repeat counter←0.
  - LONG: the repeat counter increments every cycle. On reaching R−1 it asserts `Repeat_pulse` and reloads 0.
  - HELD/LONG → IDLE on accepted release: `Pressed`←0, `Release_pulse`. All timers clear.
- **Boundary conditions**
  - If an accepted release coincides with the long or repeat expiry, the release wins: no `Long_pulse` or `Repeat_pulse` that cycle.
  - Hold and repeat counters saturate-free. Their widths are $clog2(L) and $clog2(R).
  - A button held through reset deassertion is detected as a fresh press D+2 cycles after reset release.
  - Reset mid-hold drops `Pressed` with no `Release_pulse`.

## Timing
- **Reset values:**
  - all outputs 0;
  - `Press_count`=0;
  - state IDLE;
  - all counters 0.
- **Latency:** raw edge to `Pressed`/`Press_pulse` is D+2 rising edges, counted from the first edge that samples the new raw level (all outputs are registered).
- **Pulse alignment:**
  - `Press_pulse` and `Release_pulse` are high in the same cycle that `Pressed` changes.
  - `Press_count` updates in that cycle.
- `Long_pulse` is high exactly L cycles after `Press_pulse`.
- `Repeat_pulse` k is high exactly L + k·R cycles after `Press_pulse` (k ≥ 1).
- Pulses are never wider than one cycle.
- Event pulses are mutually exclusive in any cycle.

## Configuration
- `BUTTON_REPEAT_EN` defined:
  - LONG runs the repeat counter;
  - `Repeat_pulse` is active as specified.
- Undefined:
  - the repeat counter is not built;
  - `Repeat_pulse` is constant 0;
  - LONG is held until release;
  - all other behaviour is identical.

## Test plan
Bench parameters: CLOCK_FREQUENCY=10000, DEBOUNCE_MS=2 (D=20), LONG_PRESS_MS=10 (L=100), REPEAT_MS=5 (R=50), ACTIVE_LOW=1.

- **Reset:** hold `Reset_n`=0 with the pin at 1 → all outputs 0. Release reset; 50 idle cycles → no pulses, `Press_count`=0.
- **Clean press/release:** drive the pin to 0 → `Pressed` and `Press_pulse` rise at edge 22, `Press_count`=1. After 60 cycles drive it to 1 → `Release_pulse` at +22, no `Long_pulse`.
- **Bounce:** toggle the pin every 5 cycles for 100 cycles, then hold it at 0 → exactly one `Press_pulse`, 22 cycles after the final edge.
- **Long press and repeat:** hold the button for 300 cycles after `Press_pulse` → `Long_pulse` at +100. With `BUTTON_REPEAT_EN`, `Repeat_pulse` at +150, +200, +250, +300; without it, none.
- **Release/long collision:** time the release so it is accepted exactly 100 cycles after `Press_pulse` → `Release_pulse` only, no `Long_pulse`.
- **Counter wrap:** perform 257 clean presses → `Press_count`=1. Assert reset mid-hold → `Pressed`=0 immediately, no `Release_pulse`.

Source files
------------

// File: rtl/button_reader.sv
// Debounced pushbutton reader: level, press/release/long/repeat strobes, press count.
// Latency: raw edge to Pressed/Press_pulse is D+2 clocks; long at +L, repeats at +L+k*R.
// No backpressure: events are single-cycle strobes. Auto-repeat built only with BUTTON_REPEAT_EN.
module button_reader #(
    parameter int CLOCK_FREQUENCY = 27000000,
    parameter int DEBOUNCE_MS     = 10,
    parameter int LONG_PRESS_MS   = 1000,
    parameter int REPEAT_MS       = 200,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic       Clock,
    input  logic       Reset_n,
    input  logic       Button_raw,
    output logic       Pressed,
    output logic       Press_pulse,
    output logic       Release_pulse,
    output logic       Long_pulse,
    output logic       Repeat_pulse,
    output logic [7:0] Press_count
);

    localparam int D  = (CLOCK_FREQUENCY / 1000) * DEBOUNCE_MS;
    localparam int L  = (CLOCK_FREQUENCY / 1000) * LONG_PRESS_MS;
    localparam int DW = $clog2(D + 1);
    localparam int HW = $clog2(L);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HELD = 2'd1,
        LONG = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic            pin_level;
    logic            sync_meta, sync_lvl;
    logic [DW-1:0]   db_cnt;
    logic            db_differ, db_done;
    logic            accept_press, accept_release;
    logic [HW-1:0]   hold_cnt, hold_nxt;
    logic            pressed_nxt;
    logic            press_nxt, release_nxt, long_nxt;
    logic [7:0]      count_nxt;

    // Normalise so that 1 always means pressed; reset value is the released level.
    assign pin_level = ACTIVE_LOW ? ~Button_raw : Button_raw;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            sync_meta <= 1'b0;
            sync_lvl  <= 1'b0;
        end else begin
            sync_meta <= pin_level;
            sync_lvl  <= sync_meta;
        end
    end

    // Any cycle matching the accepted level restarts the count, so bounce never accumulates.
    assign db_differ      = (sync_lvl != Pressed);
    assign db_done        = db_differ && (db_cnt == DW'(D - 1));
    assign accept_press   = db_done && !Pressed;
    assign accept_release = db_done && Pressed;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            db_cnt <= '0;
        end else if (!db_differ || db_done) begin
            db_cnt <= '0;
        end else begin
            db_cnt <= db_cnt + DW'(1);
        end
    end

`ifdef BUTTON_REPEAT_EN
    localparam int R  = (CLOCK_FREQUENCY / 1000) * REPEAT_MS;
    localparam int RW = (R > 1) ? $clog2(R) : 1;

    logic [RW-1:0] rep_cnt, rep_nxt;
    logic          repeat_nxt;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            rep_cnt      <= '0;
            Repeat_pulse <= 1'b0;
        end else begin
            rep_cnt      <= rep_nxt;
            Repeat_pulse <= repeat_nxt;
        end
    end
`else
    assign Repeat_pulse = 1'b0;
`endif

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state         <= IDLE;
            hold_cnt      <= '0;
            Pressed       <= 1'b0;
            Press_pulse   <= 1'b0;
            Release_pulse <= 1'b0;
            Long_pulse    <= 1'b0;
            Press_count   <= 8'd0;
        end else begin
            state         <= state_nxt;
            hold_cnt      <= hold_nxt;
            Pressed       <= pressed_nxt;
            Press_pulse   <= press_nxt;
            Release_pulse <= release_nxt;
            Long_pulse    <= long_nxt;
            Press_count   <= count_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        hold_nxt    = hold_cnt;
        pressed_nxt = Pressed;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
        long_nxt    = 1'b0;
        count_nxt   = Press_count;
`ifdef BUTTON_REPEAT_EN
        rep_nxt     = rep_cnt;
        repeat_nxt  = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (accept_press) begin
                    state_nxt   = HELD;
                    pressed_nxt = 1'b1;
                    press_nxt   = 1'b1;
                    count_nxt   = Press_count + 8'd1;
                    hold_nxt    = '0;
                end
            end
            HELD: begin
                // Release takes priority over a coincident long-press expiry.
                if (accept_release) begin
                    state_nxt   = IDLE;
                    pressed_nxt = 1'b0;
                    release_nxt = 1'b1;
                    hold_nxt    = '0;
                end else if (hold_cnt == HW'(L - 1)) begin
                    state_nxt = LONG;
                    long_nxt  = 1'b1;
                    hold_nxt  = '0;
`ifdef BUTTON_REPEAT_EN
                    rep_nxt   = '0;
`endif
                end else begin
                    hold_nxt = hold_cnt + HW'(1);
                end
            end
            LONG: begin
                if (accept_release) begin
                    state_nxt   = IDLE;
                    pressed_nxt = 1'b0;
                    release_nxt = 1'b1;
                    hold_nxt    = '0;
`ifdef BUTTON_REPEAT_EN
                    rep_nxt     = '0;
`endif
                end else begin
`ifdef BUTTON_REPEAT_EN
                    if (rep_cnt == RW'(R - 1)) begin
                        rep_nxt    = '0;
                        repeat_nxt = 1'b1;
                    end else begin
                        rep_nxt = rep_cnt + RW'(1);
                    end
`endif
                end
            end
            default: begin
                state_nxt   = IDLE;
                pressed_nxt = 1'b0;
                hold_nxt    = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_button_reader.sv
// Directed bench for button_reader with D=20, L=100, R=50, active-low pin.
module tb_button_reader;

    logic       Clock = 1'b0;
    logic       Reset_n;
    logic       Button_raw;
    logic       Pressed;
    logic       Press_pulse;
    logic       Release_pulse;
    logic       Long_pulse;
    logic       Repeat_pulse;
    logic [7:0] Press_count;

    int vectors = 0;
    int miscompares = 0;

    int cyc = 0;
    int press_seen, release_seen, long_seen, repeat_seen;
    int t_press, t_release, t_long;
    int rep_t [0:7];
    int width_err = 0;
    int excl_err = 0;
    logic prev_p = 1'b0, prev_r = 1'b0, prev_l = 1'b0, prev_k = 1'b0;

    button_reader #(
        .CLOCK_FREQUENCY(10000),
        .DEBOUNCE_MS    (2),
        .LONG_PRESS_MS  (10),
        .REPEAT_MS      (5),
        .ACTIVE_LOW     (1'b1)
    ) dut (
        .Clock        (Clock),
        .Reset_n      (Reset_n),
        .Button_raw   (Button_raw),
        .Pressed      (Pressed),
        .Press_pulse  (Press_pulse),
        .Release_pulse(Release_pulse),
        .Long_pulse   (Long_pulse),
        .Repeat_pulse (Repeat_pulse),
        .Press_count  (Press_count)
    );

    always #5 Clock = ~Clock;

    task automatic clear_stats();
        press_seen   = 0;
        release_seen = 0;
        long_seen    = 0;
        repeat_seen  = 0;
        t_press      = -1;
        t_release    = -1;
        t_long       = -1;
    endtask

    // One clock, then sample 1 time unit after the rising edge and log events.
    task automatic tick();
        @(posedge Clock);
        #1;
        cyc++;
        if (Press_pulse)   begin press_seen++;   t_press   = cyc; end
        if (Release_pulse) begin release_seen++; t_release = cyc; end
        if (Long_pulse)    begin long_seen++;    t_long    = cyc; end
        if (Repeat_pulse) begin
            if (repeat_seen < 8) rep_t[repeat_seen] = cyc;
            repeat_seen++;
        end
        if ((int'(Press_pulse) + int'(Release_pulse) + int'(Long_pulse) + int'(Repeat_pulse)) > 1)
            excl_err++;
        if ((Press_pulse && prev_p) || (Release_pulse && prev_r) ||
            (Long_pulse && prev_l) || (Repeat_pulse && prev_k))
            width_err++;
        prev_p = Press_pulse;
        prev_r = Release_pulse;
        prev_l = Long_pulse;
        prev_k = Repeat_pulse;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        Reset_n    = 1'b0;
        Button_raw = 1'b1;
        clear_stats();
        run(3);
        vectors++;
        if ({Pressed, Press_pulse, Release_pulse, Long_pulse, Repeat_pulse, Press_count} !== 13'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b, expected all zero",
                     {Pressed, Press_pulse, Release_pulse, Long_pulse, Repeat_pulse, Press_count});
        end
        Reset_n = 1'b1;
        clear_stats();
        run(50);
        vectors++;
        if ((press_seen + release_seen + long_seen + repeat_seen) != 0 || Press_count !== 8'd0 || Pressed !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle: pulses=%0d count=%0d pressed=%b, expected 0/0/0",
                     press_seen + release_seen + long_seen + repeat_seen, Press_count, Pressed);
        end
    endtask

    task automatic test_clean();
        clear_stats();
        Button_raw = 1'b0;
        run(21);
        vectors++;
        if (Pressed !== 1'b0) begin
            miscompares++;
            $display("FAIL clean_early: Pressed=%b at edge 21, expected 0", Pressed);
        end
        run(1);
        vectors++;
        if ({Pressed, Press_pulse, Press_count} !== {1'b1, 1'b1, 8'd1}) begin
            miscompares++;
            $display("FAIL clean_press: pressed/pulse/count=%b/%b/%0d at edge 22, expected 1/1/1",
                     Pressed, Press_pulse, Press_count);
        end
        run(60);
        Button_raw = 1'b1;
        run(21);
        vectors++;
        if (Pressed !== 1'b1 || release_seen != 0) begin
            miscompares++;
            $display("FAIL clean_release_early: Pressed=%b releases=%0d, expected 1/0", Pressed, release_seen);
        end
        run(1);
        vectors++;
        if ({Pressed, Release_pulse} !== 2'b01) begin
            miscompares++;
            $display("FAIL clean_release: pressed/pulse=%b/%b at +22, expected 0/1", Pressed, Release_pulse);
        end
        run(10);
        vectors++;
        if (long_seen != 0 || press_seen != 1 || release_seen != 1) begin
            miscompares++;
            $display("FAIL clean_counts: long=%0d press=%0d release=%0d, expected 0/1/1",
                     long_seen, press_seen, release_seen);
        end
    endtask

    task automatic test_bounce();
        int t0;
        clear_stats();
        for (int i = 0; i < 20; i++) begin
            Button_raw = (i % 2 == 0) ? 1'b0 : 1'b1;
            run(5);
        end
        Button_raw = 1'b0;
        t0 = cyc;
        run(30);
        vectors++;
        if (press_seen != 1 || (t_press - t0) != 22) begin
            miscompares++;
            $display("FAIL bounce_press: presses=%0d delay=%0d, expected 1/22", press_seen, t_press - t0);
        end
        Button_raw = 1'b1;
        run(30);
        vectors++;
        if (release_seen != 1 || Press_count !== 8'd2) begin
            miscompares++;
            $display("FAIL bounce_release: releases=%0d count=%0d, expected 1/2", release_seen, Press_count);
        end
    endtask

    task automatic test_long_repeat();
        clear_stats();
        Button_raw = 1'b0;
        run(22);
        run(300);
        vectors++;
        if (long_seen != 1 || (t_long - t_press) != 100) begin
            miscompares++;
            $display("FAIL long_pulse: count=%0d offset=%0d, expected 1/100", long_seen, t_long - t_press);
        end
`ifdef BUTTON_REPEAT_EN
        vectors++;
        if (repeat_seen != 4 || (rep_t[0] - t_press) != 150 || (rep_t[1] - t_press) != 200 ||
            (rep_t[2] - t_press) != 250 || (rep_t[3] - t_press) != 300) begin
            miscompares++;
            $display("FAIL repeat_times: count=%0d first=%0d last=%0d, expected 4/150/300",
                     repeat_seen, rep_t[0] - t_press, rep_t[3] - t_press);
        end
`else
        vectors++;
        if (repeat_seen != 0) begin
            miscompares++;
            $display("FAIL repeat_disabled: repeats=%0d, expected 0", repeat_seen);
        end
`endif
        Button_raw = 1'b1;
        run(25);
        vectors++;
        if (release_seen != 1 || Pressed !== 1'b0) begin
            miscompares++;
            $display("FAIL long_release: releases=%0d pressed=%b, expected 1/0", release_seen, Pressed);
        end
    endtask

    task automatic test_collision();
        clear_stats();
        Button_raw = 1'b0;
        run(22);
        vectors++;
        if (Press_pulse !== 1'b1) begin
            miscompares++;
            $display("FAIL collision_press: Press_pulse=%b, expected 1", Press_pulse);
        end
        run(78);
        Button_raw = 1'b1;
        run(22);
        vectors++;
        if ({Release_pulse, Long_pulse, Pressed} !== 3'b100 || (cyc - t_press) != 100) begin
            miscompares++;
            $display("FAIL collision_edge: rel/long/pressed=%b%b%b at +%0d, expected 100 at +100",
                     Release_pulse, Long_pulse, Pressed, cyc - t_press);
        end
        run(10);
        vectors++;
        if (long_seen != 0 || release_seen != 1) begin
            miscompares++;
            $display("FAIL collision_counts: long=%0d release=%0d, expected 0/1", long_seen, release_seen);
        end
    endtask

    task automatic test_wrap_and_reset();
        Reset_n = 1'b0;
        run(2);
        Reset_n = 1'b1;
        run(5);
        clear_stats();
        for (int i = 0; i < 257; i++) begin
            Button_raw = 1'b0;
            run(25);
            if (i == 255) begin
                vectors++;
                if (Press_count !== 8'd0) begin
                    miscompares++;
                    $display("FAIL wrap_256: count=%0d, expected 0", Press_count);
                end
            end
            Button_raw = 1'b1;
            run(25);
        end
        vectors++;
        if (Press_count !== 8'd1 || press_seen != 257) begin
            miscompares++;
            $display("FAIL wrap_257: count=%0d presses=%0d, expected 1/257", Press_count, press_seen);
        end
        Button_raw = 1'b0;
        run(30);
        clear_stats();
        Reset_n = 1'b0;
        #1;
        vectors++;
        if (Pressed !== 1'b0 || Press_count !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_mid_hold: pressed=%b count=%0d, expected 0/0", Pressed, Press_count);
        end
        run(3);
        Reset_n = 1'b1;
        run(21);
        vectors++;
        if (release_seen != 0 || Pressed !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_no_release: releases=%0d pressed=%b, expected 0/0", release_seen, Pressed);
        end
        run(1);
        vectors++;
        if ({Pressed, Press_pulse, Press_count} !== {1'b1, 1'b1, 8'd1}) begin
            miscompares++;
            $display("FAIL held_through_reset: pressed/pulse/count=%b/%b/%0d, expected 1/1/1",
                     Pressed, Press_pulse, Press_count);
        end
        Button_raw = 1'b1;
        run(30);
    endtask

    task automatic test_pulse_rules();
        vectors++;
        if (width_err != 0 || excl_err != 0) begin
            miscompares++;
            $display("FAIL pulse_rules: wide=%0d overlapping=%0d, expected 0/0", width_err, excl_err);
        end
    endtask

    initial begin
        test_reset();
        test_clean();
        run(30);
        test_bounce();
        run(30);
        test_long_repeat();
        run(30);
        test_collision();
        run(30);
        test_wrap_and_reset();
        test_pulse_rules();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
